mul_issue_ctrl: RTL and testbench

- Execute-stage controller that sequences the shared 32x32 iterative unsigned multiplier for RV32M MUL/MULH/MULHSU/MULHU.
- Takes one request from the pipeline. Converts signed operands to magnitudes and launches the multiplier with a single-cycle start pulse.
- Waits for completion, then applies the sign correction and selects the low or high result word.
- Holds a valid/ready response for writeback and asserts busy so hazard logic can stall issue.

---
 rtl/mul_ctrl_pkg.sv | 48 ++++
 rtl/mul_sign_fixup.sv | 16 +
 rtl/mul_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared types and helpers for the RV32M multiply issue controller.
// Holds the opcode encoding, controller state encoding, operand sign class,
// and the magnitude/negate helpers used by the controller and its fixup stage.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_CORRECT = 3'd3,
    S_RESP    = 3'd4
  } ctrl_state_e;

  // Signedness class of an operand pair; MUL and MULHU share UU.
  typedef enum logic [1:0] {
    CLS_UU = 2'd0,
    CLS_SU = 2'd1,
    CLS_SS = 2'd2
  } sign_cls_e;

  // Two's-complement magnitude when neg is set. 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  function automatic sign_cls_e op_class(input mul_op_e op);
    sign_cls_e cls;
    case (op)
      OP_MULH:   cls = CLS_SS;
      OP_MULHSU: cls = CLS_SU;
      default:   cls = CLS_UU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mul_sign_fixup.sv
// mul_sign_fixup: combinational sign correction of the 64-bit unsigned product
// followed by selection of the low (MUL) or high (MULH*) result word.
module mul_sign_fixup
  import mul_ctrl_pkg::*;
(
  input  logic [63:0] prod_i,
  input  logic        neg_i,
  input  logic        hi_i,
  output logic [63:0] prod_o,
  output logic [31:0] word_o
);

  assign prod_o = neg_i ? neg64(prod_i) : prod_i;
  assign word_o = hi_i ? prod_o[63:32] : prod_o[31:0];

endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: execute-stage sequencer for the shared 32x32 iterative
// unsigned multiplier (RV32M MUL/MULH/MULHSU/MULHU). Operands are reduced to
// magnitudes, the multiplier is launched with a one-cycle pulse, the product
// is sign-corrected and the selected word is held as a valid/ready response.
// Optional: define MUL_RESULT_REUSE_EN to add a one-entry result cache that
// lets a repeated operand pair skip the multiplier entirely.
module mul_issue_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,  // only 32 is supported
  parameter int TIMEOUT_CYC = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [4:0]        req_rd,
  input  logic              flush,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  input  logic [2*XLEN-1:0] mul_product,
  input  logic              mul_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              busy
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

  ctrl_state_e     state_q, state_d;
  mul_op_e         op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic            neg_res_q, neg_res_d;
  logic            rdy_prev_q;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [63:0]     prod_q, prod_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  mul_op_e req_op_e;
  logic    req_neg_a, req_neg_b;
  logic    rdy_rise;

  logic [63:0] fix_prod, fix_p;
  logic [31:0] fix_word;
  logic        fix_neg, fix_hi;

  assign req_op_e  = mul_op_e'(req_op);
  assign req_neg_a = req_rs1[31] & ((req_op_e == OP_MULH) || (req_op_e == OP_MULHSU));
  assign req_neg_b = req_rs2[31] & (req_op_e == OP_MULH);
  // A ready level left high by a previous operation must not count as done.
  assign rdy_rise  = mul_ready & ~rdy_prev_q;

`ifdef MUL_RESULT_REUSE_EN
  logic        c_vld_q, c_vld_d;
  logic [31:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d;
  sign_cls_e   c_cls_q, c_cls_d;
  logic [63:0] c_prod_q, c_prod_d;
  logic        hit_q, hit_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
  sign_cls_e   cls_q, cls_d;
  sign_cls_e   req_cls;
  logic        req_hit;

  assign req_cls = op_class(req_op_e);
  // MUL only needs the low word, which is identical for every sign class.
  assign req_hit = c_vld_q && (c_rs1_q == req_rs1) && (c_rs2_q == req_rs2) &&
                   ((req_op_e == OP_MUL) || (c_cls_q == req_cls));
  // Cached products are already corrected, so a hit bypasses the negate.
  assign fix_prod = hit_q ? c_prod_q : prod_q;
  assign fix_neg  = hit_q ? 1'b0 : neg_res_q;
`else
  assign fix_prod = prod_q;
  assign fix_neg  = neg_res_q;
`endif
  assign fix_hi = (op_q != OP_MUL);

  mul_sign_fixup u_fixup (
    .prod_i (fix_prod),
    .neg_i  (fix_neg),
    .hi_i   (fix_hi),
    .prod_o (fix_p),
    .word_o (fix_word)
  );

  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign resp_data = rdata_q;
  assign resp_rd   = rd_q;
  assign resp_err  = err_q;
  assign busy      = (state_q != S_IDLE);

  // Next-state, handshake outputs and register updates for the issue FSM.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    wd_d      = wd_q;
    prod_d    = prod_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef MUL_RESULT_REUSE_EN
    c_vld_d   = c_vld_q;
    c_rs1_d   = c_rs1_q;
    c_rs2_d   = c_rs2_q;
    c_cls_d   = c_cls_q;
    c_prod_d  = c_prod_q;
    hit_d     = hit_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    cls_d     = cls_q;
`endif
    req_ready  = 1'b0;
    mul_start  = 1'b0;
    resp_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = ~flush;
        if (req_valid && !flush) begin
          op_d      = req_op_e;
          rd_d      = req_rd;
          a_d       = abs32(req_rs1, req_neg_a);
          b_d       = abs32(req_rs2, req_neg_b);
          neg_res_d = req_neg_a ^ req_neg_b;
          wd_d      = '0;
          err_d     = 1'b0;
          state_d   = S_LAUNCH;
`ifdef MUL_RESULT_REUSE_EN
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          cls_d = req_cls;
          hit_d = req_hit;
          if (req_hit) state_d = S_CORRECT;
`endif
        end
      end
      S_LAUNCH: begin
        mul_start = 1'b1;
        wd_d      = wd_q + WD_W'(1);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (rdy_rise) begin
          prod_d  = mul_product;
          state_d = S_CORRECT;
        end else if (wd_q == WD_LIMIT) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
`ifdef MUL_RESULT_REUSE_EN
          c_vld_d = 1'b0;
`endif
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_CORRECT: begin
        // prod_q is left holding the corrected product.
        prod_d  = fix_p;
        rdata_d = fix_word;
        err_d   = 1'b0;
        state_d = S_RESP;
`ifdef MUL_RESULT_REUSE_EN
        if (!hit_q) begin
          c_vld_d  = 1'b1;
          c_rs1_d  = rs1_q;
          c_rs2_d  = rs2_q;
          c_cls_d  = cls_q;
          c_prod_d = fix_p;
        end
`endif
      end
      S_RESP: begin
        resp_valid = ~flush;
        if (resp_ready && !flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over completion and over the response handshake.
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
`ifdef MUL_RESULT_REUSE_EN
      c_vld_d = 1'b0;
`endif
    end
  end

  // Control state and output-visible registers, cleared by async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_MUL;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rdy_prev_q <= 1'b0;
      wd_q       <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef MUL_RESULT_REUSE_EN
      c_vld_q    <= 1'b0;
      hit_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rdy_prev_q <= mul_ready;
      wd_q       <= wd_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef MUL_RESULT_REUSE_EN
      c_vld_q    <= c_vld_d;
      hit_q      <= hit_d;
`endif
    end
  end

  // Datapath payload registers; only read when the control state qualifies them.
  always_ff @(posedge clk) begin
    neg_res_q <= neg_res_d;
    prod_q    <= prod_d;
`ifdef MUL_RESULT_REUSE_EN
    c_rs1_q   <= c_rs1_d;
    c_rs2_q   <= c_rs2_d;
    c_cls_q   <= c_cls_d;
    c_prod_q  <= c_prod_d;
    rs1_q     <= rs1_d;
    rs2_q     <= rs2_d;
    cls_q     <= cls_d;
`endif
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed bench for mul_issue_ctrl with a small
// multiplier model (fixed latency, optional hang) and hand-computed results.
module tb_mul_issue_ctrl;

  localparam int M_LAT    = 3;
  localparam int LAT_NORM = M_LAT + 3;
  localparam int LAT_TO   = 63 + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        mul_start;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_product;
  logic        mul_ready;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err, busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.XLEN(32), .TIMEOUT_CYC(63)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_rd      (req_rd),
    .flush       (flush),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_ready   (mul_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_rd     (resp_rd),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  // Multiplier model: ready rises M_LAT cycles after the start pulse and stays
  // high until one cycle after the next start, so a stale level is visible.
  logic [63:0] mdl_prod = 64'd0;
  logic        mdl_rdy  = 1'b0;
  logic        mdl_arm  = 1'b0;
  logic        mdl_hang = 1'b0;
  int          mdl_cnt  = 0;

  assign mul_product = mdl_prod;
  assign mul_ready   = mdl_rdy;

  always @(posedge clk) begin
    if (mul_start) begin
      mdl_prod <= {32'd0, mul_a} * {32'd0, mul_b};
      mdl_cnt  <= M_LAT - 1;
      mdl_arm  <= 1'b1;
    end else if (mdl_arm) begin
      if (mdl_cnt == 1 && !mdl_hang) begin
        mdl_rdy <= 1'b1;
        mdl_arm <= 1'b0;
      end else begin
        mdl_rdy <= 1'b0;
        if (mdl_cnt > 1) mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One full transaction from the IDLE negedge to the idle state after the handshake.
  task automatic do_op(input string tag, input logic [1:0] op,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] rd,
                       input int exp_starts, input logic [31:0] exp_a, input logic [31:0] exp_b,
                       input logic [31:0] exp_data, input logic exp_err,
                       input int exp_lat, input int hold);
    int starts;
    int lat;
    starts = 0;
    lat    = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_rd    = rd;
    #1 check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (mul_start) begin
        starts++;
        check({tag, ".mul_a"}, 64'(mul_a), 64'(exp_a));
        check({tag, ".mul_b"}, 64'(mul_b), 64'(exp_b));
      end
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".starts"}, 64'(starts), 64'(exp_starts));
    check({tag, ".data"}, 64'(resp_data), 64'(exp_data));
    check({tag, ".rd"}, 64'(resp_rd), 64'(rd));
    check({tag, ".err"}, 64'(resp_err), 64'(exp_err));
    check({tag, ".req_ready_resp"}, 64'(req_ready), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, ".hold_data"}, 64'(resp_data), 64'(exp_data));
      check({tag, ".hold_req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    check({tag, ".idle_valid"}, 64'(resp_valid), 64'd0);
    check({tag, ".idle_req_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got run still active expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int vcnt;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_rs1    = '0;
    req_rs2    = '0;
    req_rd     = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.req_ready", 64'(req_ready), 64'd1);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.mul_start", 64'(mul_start), 64'd0);
    check("rst.resp_valid", 64'(resp_valid), 64'd0);
    check("rst.resp_data", 64'(resp_data), 64'd0);
    check("rst.resp_err", 64'(resp_err), 64'd0);
    check("rst.mul_a", 64'(mul_a), 64'd0);
    check("rst.mul_b", 64'(mul_b), 64'd0);
    check("rst.resp_rd", 64'(resp_rd), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd5, 1, 32'd7, 32'd6, 32'd42, 1'b0, LAT_NORM, 0);
    do_op("mulh_neg", 2'b01, 32'hFFFF_FFFE, 32'd3, 5'd12, 1, 32'd2, 32'd3,
          32'hFFFF_FFFF, 1'b0, LAT_NORM, 0);
`ifdef MUL_RESULT_REUSE_EN
    do_op("mul_reuse", 2'b00, 32'hFFFF_FFFE, 32'd3, 5'd13, 0, 32'd0, 32'd0,
          32'hFFFF_FFFA, 1'b0, 2, 0);
`else
    do_op("mul_reuse", 2'b00, 32'hFFFF_FFFE, 32'd3, 5'd13, 1, 32'hFFFF_FFFE, 32'd3,
          32'hFFFF_FFFA, 1'b0, LAT_NORM, 0);
`endif
    do_op("mulhsu_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1, 32'h8000_0000,
          32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LAT_NORM, 0);
    do_op("mulhu_hold", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LAT_NORM, 5);

    // Flush while waiting on the multiplier: no response may appear.
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_rs1   = 32'hFFFF_FFFE;
    req_rs2   = 32'd3;
    req_rd    = 5'd20;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("flush.launch", 64'(mul_start), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush.req_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush.busy", 64'(busy), 64'd0);
    check("flush.req_ready", 64'(req_ready), 64'd1);
    vcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) vcnt++;
    end
    check("flush.no_resp", 64'(vcnt), 64'd0);

    do_op("mul_3x5", 2'b00, 32'd3, 32'd5, 5'd3, 1, 32'd3, 32'd5, 32'd15, 1'b0, LAT_NORM, 0);

    mdl_hang = 1'b1;
    do_op("timeout", 2'b11, 32'd5, 32'd5, 5'd9, 1, 32'd5, 32'd5, 32'd0, 1'b1, LAT_TO, 0);
    mdl_hang = 1'b0;

    // Timeout invalidates any cached entry, so this launches again.
    do_op("mul_3x5_again", 2'b00, 32'd3, 32'd5, 5'd4, 1, 32'd3, 32'd5, 32'd15, 1'b0,
          LAT_NORM, 0);

    // Asynchronous reset in the launch cycle.
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_rs1   = 32'd9;
    req_rs2   = 32'd9;
    req_rd    = 5'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("arst.launch", 64'(mul_start), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("arst.mul_start", 64'(mul_start), 64'd0);
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.req_ready", 64'(req_ready), 64'd1);
    check("arst.mul_a", 64'(mul_a), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_op("mul_after_rst", 2'b00, 32'd3, 32'd5, 5'd6, 1, 32'd3, 32'd5, 32'd15, 1'b0,
          LAT_NORM, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
